// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch requester, the data requester and the
// single-port RAM connections of mem_port_arbiter.
// The slave modport is the arbiter's view. The master modport is the opposite
// side: the CPU pipeline plus the RAM.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // Fetch requester (read only)
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    // Data requester (MemoryAccess stage)
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [3:0]            dm_strobe;
    logic                  dm_gnt;
    logic                  dm_rvalid;
    logic [DATA_WIDTH-1:0] dm_rdata;

    // Single-port RAM
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_write_data;
    logic                  ram_write_enable;
    logic [3:0]            ram_write_strobe;
    logic [DATA_WIDTH-1:0] ram_read_data;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_strobe,
        output dm_gnt, dm_rvalid, dm_rdata,
        output ram_address, ram_write_data, ram_write_enable, ram_write_strobe,
        input  ram_read_data
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_strobe,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  ram_address, ram_write_data, ram_write_enable, ram_write_strobe,
        output ram_read_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data RAM between instruction fetch
// and the MemoryAccess stage.
// Each transaction runs as IDLE (grant) -> ISSUE (RAM cycle) -> WAIT (read
// latency). A write ends after ISSUE. A completed read pulses the owner's
// rvalid in the IDLE cycle that follows.
// The data port has priority over fetch. A streak counter prevents fetch from
// being starved indefinitely.
// Optional feature: define MEM_ARB_PERF_CNT_EN to add the saturating stall
// counters perf_if_stall / perf_dm_stall.
// Legal ranges: READ_LATENCY 1..4, MAX_DATA_STREAK 1..15.
module mem_port_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int READ_LATENCY    = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_port_arbiter_if.slave      bus,
    output logic                   busy
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]            perf_if_stall,
    output logic [31:0]            perf_dm_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] LAT_LOAD   = 2'(READ_LATENCY - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    // Saturating 32-bit increment used by the stall counters
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic [1:0]            lat_cnt_r;
    logic [3:0]            streak_r;
    logic                  txn_we_r;
    logic                  txn_owner_if_r;

    logic                  if_gnt_s;
    logic                  dm_gnt_s;
    logic                  streak_at_max_s;
    logic                  capture_s;
    logic                  issue_read_s;

    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [DATA_WIDTH-1:0] ram_wdata_r;
    logic                  ram_we_r;
    logic [3:0]            ram_strb_r;

    logic [DATA_WIDTH-1:0] if_rdata_r;
    logic [DATA_WIDTH-1:0] dm_rdata_r;
    logic                  if_rvalid_r;
    logic                  dm_rvalid_r;
    logic                  busy_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (if_gnt_s || dm_gnt_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (txn_we_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_r == 2'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: grants in IDLE (data first unless fetch has waited out the streak) and phase decodes
    always_comb begin
        if_gnt_s        = 1'b0;
        dm_gnt_s        = 1'b0;
        streak_at_max_s = (streak_r == STREAK_MAX);
        issue_read_s    = (state_r == ST_ISSUE) && !txn_we_r;
        capture_s       = (state_r == ST_WAIT) && (lat_cnt_r == 2'd0);
        if ((state_r == ST_IDLE) && !rst) begin
            if (bus.dm_req && !(bus.if_req && streak_at_max_s)) begin
                dm_gnt_s = 1'b1;
            end else if (bus.if_req) begin
                if_gnt_s = 1'b1;
            end else begin
                dm_gnt_s = 1'b0;
                if_gnt_s = 1'b0;
            end
        end else begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end
    end

    // Read latency counter: loaded at a read ISSUE, counts down in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt_r <= 2'd0;
        end else if (issue_read_s) begin
            lat_cnt_r <= LAT_LOAD;
        end else if ((state_r == ST_WAIT) && (lat_cnt_r != 2'd0)) begin
            lat_cnt_r <= lat_cnt_r - 2'd1;
        end else begin
            lat_cnt_r <= lat_cnt_r;
        end
    end

    // Granted transaction kind and the owner of the pending read
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_we_r       <= 1'b0;
            txn_owner_if_r <= 1'b0;
        end else if (dm_gnt_s) begin
            txn_we_r       <= bus.dm_we;
            txn_owner_if_r <= 1'b0;
        end else if (if_gnt_s) begin
            txn_we_r       <= 1'b0;
            txn_owner_if_r <= 1'b1;
        end else begin
            txn_we_r       <= txn_we_r;
            txn_owner_if_r <= txn_owner_if_r;
        end
    end

    // Data-grant streak: counts data grants taken while fetch was waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_r <= 4'd0;
        end else if (if_gnt_s) begin
            streak_r <= 4'd0;
        end else if (dm_gnt_s) begin
            if (!bus.if_req) begin
                streak_r <= 4'd0;
            end else if (streak_r < STREAK_MAX) begin
                streak_r <= streak_r + 4'd1;
            end else begin
                streak_r <= streak_r;
            end
        end else begin
            streak_r <= streak_r;
        end
    end

    // RAM drive: loaded at grant so it is valid in ISSUE; write controls live only for that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_r  <= '0;
            ram_wdata_r <= '0;
            ram_we_r    <= 1'b0;
            ram_strb_r  <= 4'd0;
        end else if (dm_gnt_s) begin
            ram_addr_r  <= bus.dm_addr;
            ram_we_r    <= bus.dm_we;
            ram_wdata_r <= bus.dm_we ? bus.dm_wdata : '0;
            ram_strb_r  <= bus.dm_we ? bus.dm_strobe : 4'd0;
        end else if (if_gnt_s) begin
            ram_addr_r  <= bus.if_addr;
            ram_we_r    <= 1'b0;
            ram_wdata_r <= '0;
            ram_strb_r  <= 4'd0;
        end else begin
            ram_addr_r  <= ram_addr_r;
            ram_we_r    <= 1'b0;
            ram_wdata_r <= '0;
            ram_strb_r  <= 4'd0;
        end
    end

    // Read completion: capture RAM data for the owner and pulse its rvalid in the following IDLE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_r  <= '0;
            dm_rdata_r  <= '0;
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
        end else begin
            if_rvalid_r <= capture_s && txn_owner_if_r;
            dm_rvalid_r <= capture_s && !txn_owner_if_r;
            if (capture_s && txn_owner_if_r) begin
                if_rdata_r <= bus.ram_read_data;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            if (capture_s && !txn_owner_if_r) begin
                dm_rdata_r <= bus.ram_read_data;
            end else begin
                dm_rdata_r <= dm_rdata_r;
            end
        end
    end

    // Busy flag registered from the next state, so it tracks "state is not IDLE"
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall_r;
    logic [31:0] perf_dm_stall_r;

    // Stall counters: cycles in which a requester holds req without receiving a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_stall_r <= 32'd0;
            perf_dm_stall_r <= 32'd0;
        end else begin
            if (bus.if_req && !if_gnt_s) begin
                perf_if_stall_r <= sat_inc32(perf_if_stall_r);
            end else begin
                perf_if_stall_r <= perf_if_stall_r;
            end
            if (bus.dm_req && !dm_gnt_s) begin
                perf_dm_stall_r <= sat_inc32(perf_dm_stall_r);
            end else begin
                perf_dm_stall_r <= perf_dm_stall_r;
            end
        end
    end

    assign perf_if_stall = perf_if_stall_r;
    assign perf_dm_stall = perf_dm_stall_r;
`endif

    assign bus.if_gnt           = if_gnt_s;
    assign bus.dm_gnt           = dm_gnt_s;
    assign bus.if_rvalid        = if_rvalid_r;
    assign bus.dm_rvalid        = dm_rvalid_r;
    assign bus.if_rdata         = if_rdata_r;
    assign bus.dm_rdata         = dm_rdata_r;
    assign bus.ram_address      = ram_addr_r;
    assign bus.ram_write_data   = ram_wdata_r;
    assign bus.ram_write_enable = ram_we_r;
    assign bus.ram_write_strobe = ram_strb_r;
    assign busy                 = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic for
// mem_port_arbiter (READ_LATENCY=3, MAX_DATA_STREAK=4).
// The reference model is a cycle timeline. Each grant schedules its RAM cycle,
// its completion cycle and the next free cycle. Every cycle, the DUT outputs
// are compared against that timeline.
module tb_mem_port_arbiter;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int RL   = 3;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall;
    logic [31:0] perf_dm_stall;
`endif

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_dm_stall (perf_dm_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // timeline model
    int          cyc;
    int          next_free;
    int          streak;
    int          issue_cyc;
    logic        issue_we;
    logic [31:0] issue_wdata;
    logic [3:0]  issue_strb;
    logic [31:0] m_ram_addr;
    bit          rd_pend;
    bit          rd_owner_if;
    int          rd_done;
    logic [31:0] m_if_rdata;
    logic [31:0] m_dm_rdata;
    logic [31:0] m_perf_if;
    logic [31:0] m_perf_dm;
    bit          last_if_gnt;
    bit          last_dm_gnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        next_free  = cyc + 1;
        streak     = 0;
        issue_cyc  = -10;
        issue_we   = 1'b0;
        m_ram_addr = 32'd0;
        rd_pend    = 1'b0;
        m_if_rdata = 32'd0;
        m_dm_rdata = 32'd0;
        m_perf_if  = 32'd0;
        m_perf_dm  = 32'd0;
    endtask

    // Compare one cycle against the model, advance the model, move to the next cycle.
    // The caller sets inputs at the negedge before calling.
    task automatic step();
        bit idle, want_if, want_dm, e_if, e_dm, is_wr_issue, e_ifv, e_dmv;
        #2;
        idle    = (cyc >= next_free);
        want_if = bus.if_req;
        want_dm = bus.dm_req;
        e_dm    = idle && !rst && want_dm && !(want_if && streak == MAXS);
        e_if    = idle && !rst && want_if && !e_dm;
        is_wr_issue = (cyc == issue_cyc) && issue_we;
        e_ifv   = rd_pend && (cyc == rd_done) && rd_owner_if;
        e_dmv   = rd_pend && (cyc == rd_done) && !rd_owner_if;

        chk("if_gnt", bus.if_gnt, e_if);
        chk("dm_gnt", bus.dm_gnt, e_dm);
        chk("busy", busy, !idle);
        chk("ram_address", bus.ram_address, m_ram_addr);
        chk("ram_write_enable", bus.ram_write_enable, is_wr_issue);
        chk("ram_write_data", bus.ram_write_data, is_wr_issue ? issue_wdata : 32'd0);
        chk("ram_write_strobe", bus.ram_write_strobe, is_wr_issue ? issue_strb : 4'd0);
        chk("if_rvalid", bus.if_rvalid, e_ifv);
        chk("dm_rvalid", bus.dm_rvalid, e_dmv);
        chk("if_rdata", bus.if_rdata, m_if_rdata);
        chk("dm_rdata", bus.dm_rdata, m_dm_rdata);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_if_stall", perf_if_stall, m_perf_if);
        chk("perf_dm_stall", perf_dm_stall, m_perf_dm);
`endif
        last_if_gnt = bus.if_gnt;
        last_dm_gnt = bus.dm_gnt;

        if (rd_pend && cyc == rd_done - 1) begin
            if (rd_owner_if) m_if_rdata = bus.ram_read_data;
            else             m_dm_rdata = bus.ram_read_data;
        end
        if (rd_pend && cyc == rd_done) rd_pend = 1'b0;
        if (want_if && !e_if && m_perf_if != 32'hFFFF_FFFF) m_perf_if = m_perf_if + 32'd1;
        if (want_dm && !e_dm && m_perf_dm != 32'hFFFF_FFFF) m_perf_dm = m_perf_dm + 32'd1;

        if (rst) begin
            model_reset();
        end else if (e_dm || e_if) begin
            issue_cyc   = cyc + 1;
            m_ram_addr  = e_dm ? bus.dm_addr : bus.if_addr;
            issue_we    = e_dm && bus.dm_we;
            issue_wdata = bus.dm_wdata;
            issue_strb  = bus.dm_strobe;
            if (issue_we) begin
                next_free = cyc + 2;
            end else begin
                rd_pend     = 1'b1;
                rd_owner_if = e_if;
                rd_done     = cyc + 2 + RL;
                next_free   = rd_done;
            end
            if (e_if)         streak = 0;
            else if (want_if) streak = (streak < MAXS) ? streak + 1 : MAXS;
            else              streak = 0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    logic [5:0] order;
    int         ngrants;

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'd0;
        bus.dm_wdata = 32'd0; bus.dm_strobe = 4'd0; bus.ram_read_data = 32'd0;
        cyc = 0;
        @(negedge clk);
        model_reset();
        next_free = 0;

        // reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_ram_addr", bus.ram_address, 32'd0);
        chk("rst_ram_we", bus.ram_write_enable, 1'b0);
        chk("rst_if_rvalid", bus.if_rvalid, 1'b0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
        step();
        rst = 1'b0;
        step();

        // simultaneous: data read wins, fetch granted at T+2+RL
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h200;
        step();
        chk("sim_dm_gnt", last_dm_gnt, 1'b1);
        chk("sim_if_gnt", last_if_gnt, 1'b0);
        bus.dm_req = 1'b0;
        steps(3);
        step();
        chk("sim_if_wait", last_if_gnt, 1'b0);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_if_5", perf_if_stall, 32'd5);
`endif
        step();
        chk("sim_if_gnt_late", last_if_gnt, 1'b1);
        bus.if_req = 1'b0;
        steps(6);

        // fetch read with literal data
        bus.ram_read_data = 32'hDEADBEEF;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        step();
        chk("f_if_gnt", last_if_gnt, 1'b1);
        chk("f_ram_addr", bus.ram_address, 32'h100);
        bus.if_req = 1'b0;
        steps(4);
        chk("f_if_rvalid", bus.if_rvalid, 1'b1);
        chk("f_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        chk("f_dm_rvalid", bus.dm_rvalid, 1'b0);
        steps(2);

        // store byte; next grant at T+2
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h204;
        bus.dm_strobe = 4'b0100; bus.dm_wdata = 32'h00AB0000;
        step();
        chk("st_dm_gnt", last_dm_gnt, 1'b1);
        chk("st_we", bus.ram_write_enable, 1'b1);
        chk("st_addr", bus.ram_address, 32'h204);
        chk("st_strb", bus.ram_write_strobe, 4'b0100);
        chk("st_wdata", bus.ram_write_data, 32'h00AB0000);
        bus.dm_we = 1'b0; bus.dm_addr = 32'h208; bus.dm_strobe = 4'd0; bus.dm_wdata = 32'd0;
        step();
        chk("st_busy_gnt", last_dm_gnt, 1'b0);
        chk("st_we_off", bus.ram_write_enable, 1'b0);
        chk("st_no_rvalid", bus.dm_rvalid, 1'b0);
        step();
        chk("st_next_gnt", last_dm_gnt, 1'b1);
        bus.dm_req = 1'b0;
        steps(6);

        // reset in the first WAIT cycle
        bus.dm_req = 1'b1; bus.dm_addr = 32'h40;
        step();
        bus.dm_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_busy", busy, 1'b0);
        chk("rr_ram_addr", bus.ram_address, 32'd0);
        chk("rr_dm_rdata", bus.dm_rdata, 32'd0);
        chk("rr_if_rdata", bus.if_rdata, 32'd0);
        steps(8);
        bus.dm_req = 1'b1; bus.dm_addr = 32'h44;
        step();
        chk("rr_fresh_gnt", last_dm_gnt, 1'b1);
        bus.dm_req = 1'b0;
        steps(6);

        // starvation: both held -> dm dm dm dm if dm
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h600;
        order = 6'd0; ngrants = 0;
        for (int k = 0; k < 100 && ngrants < 6; k++) begin
            step();
            if (last_dm_gnt || last_if_gnt) begin
                order = {order[4:0], last_dm_gnt};
                ngrants++;
            end
        end
        chk("starve_count", ngrants, 6);
        chk("starve_order", order, 6'b111101);
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        steps(8);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.ram_read_data = $urandom;
            if (!bus.if_req || last_if_gnt) begin
                bus.if_req  = ($urandom_range(0, 99) < 45);
                bus.if_addr = $urandom;
            end else if ($urandom_range(0, 99) < 3) begin
                bus.if_req = 1'b0;
            end
            if (!bus.dm_req || last_dm_gnt) begin
                bus.dm_req    = ($urandom_range(0, 99) < 55);
                bus.dm_we     = $urandom_range(0, 1) == 1;
                bus.dm_addr   = $urandom;
                bus.dm_wdata  = $urandom;
                bus.dm_strobe = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 99) < 3) begin
                bus.dm_req = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
